// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer in front of the single-port
// data memory. Requester 0 is the load/store unit, requester 1 the debug/DMA port.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests are resolved by a
// 1-bit round-robin pointer. Without it, requester 0 always wins ties.
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP, 4 ABORT.
//
// Handshake: a requester raises rN_req with a stable command and holds both
// until it sees rN_ack or rN_err. rN_gnt pulses in the IDLE cycle in which the
// command is latched, so the command inputs are free to change afterwards.
// On the memory side the latched command is presented with m_stb in ISSUE.
// It is accepted in a cycle with m_stall=0, and it is held with m_cyc until
// m_ack. If no m_ack arrives within TIMEOUT WAIT cycles, the access is
// abandoned with rN_err.
module mem_arbiter #(
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              a_clk,
    input  logic              a_rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_rd,
    input  logic [AWIDTH-1:0] r0_load_addr,
    input  logic [AWIDTH-1:0] r0_store_addr,
    input  logic [DWIDTH-1:0] r0_wdata,
    input  logic [3:0]        r0_be,
    output logic              r0_gnt,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DWIDTH-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_rd,
    input  logic [AWIDTH-1:0] r1_load_addr,
    input  logic [AWIDTH-1:0] r1_store_addr,
    input  logic [DWIDTH-1:0] r1_wdata,
    input  logic [3:0]        r1_be,
    output logic              r1_gnt,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DWIDTH-1:0] r1_rdata,
    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic              m_rd,
    output logic [AWIDTH-1:0] m_load_addr,
    output logic [AWIDTH-1:0] m_store_addr,
    output logic [DWIDTH-1:0] m_data_store,
    output logic [3:0]        m_byte_enable,
    input  logic [DWIDTH-1:0] m_read_data,
    input  logic              m_ack,
    input  logic              m_stall,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              owner_q;
    logic              op_we_q, op_rd_q;
    logic [AWIDTH-1:0] load_addr_q, store_addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DWIDTH-1:0] r0_rdata_q, r1_rdata_q;
    logic [7:0]        cnt_q, cnt_inc;
    logic              any_req, winner, grant;

    assign any_req = r0_req | r1_req;
    // Requests are only looked at in IDLE; reset suppresses a grant in its own cycle.
    assign grant   = (state_q == ST_IDLE) && any_req && !a_rst;
    // The counter saturates so it can never wrap past the limit.
    assign cnt_inc = (cnt_q == TO_LIM) ? cnt_q : cnt_q + 8'd1;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;

    // Pointer names the requester that wins the next tie; it moves to the loser of each grant.
    always_ff @(posedge a_clk) begin
        if (a_rst)      rr_ptr_q <= 1'b0;
        else if (grant) rr_ptr_q <= ~winner;
    end

    assign winner = (r0_req && r1_req) ? rr_ptr_q : ~r0_req;
`else
    assign winner = ~r0_req;
`endif

    // FSM state register.
    always_ff @(posedge a_clk) begin
        if (a_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus all bus and requester strobes.
    always_comb begin
        state_d = state_q;
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_rd    = 1'b0;
        r0_gnt  = 1'b0;
        r1_gnt  = 1'b0;
        r0_ack  = 1'b0;
        r1_ack  = 1'b0;
        r0_err  = 1'b0;
        r1_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ISSUE;
                    r0_gnt  = ~winner;
                    r1_gnt  = winner;
                end
            end
            ST_ISSUE: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                m_we  = op_we_q;
                m_rd  = op_rd_q;
                if (!m_stall) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // we/rd stay up until the memory's ack cycle, where it samples them.
                m_cyc = 1'b1;
                m_we  = op_we_q;
                m_rd  = op_rd_q;
                if (m_ack)                  state_d = ST_RESP;
                else if (cnt_inc == TO_LIM) state_d = ST_ABORT;
            end
            ST_RESP: begin
                r0_ack  = ~owner_q;
                r1_ack  = owner_q;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                r0_err  = ~owner_q;
                r1_err  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // WAIT-cycle counter: cleared when a command is issued and after an abort.
    always_ff @(posedge a_clk) begin
        if (a_rst)                                cnt_q <= '0;
        else if (grant)                           cnt_q <= '0;
        else if (state_q == ST_WAIT && !m_ack)    cnt_q <= cnt_inc;
        else if (state_q == ST_ABORT)             cnt_q <= '0;
    end

    // Latch the winner's command at grant; it drives the memory bus until the next grant.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            owner_q      <= 1'b0;
            op_we_q      <= 1'b0;
            op_rd_q      <= 1'b0;
            load_addr_q  <= '0;
            store_addr_q <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else if (grant) begin
            owner_q      <= winner;
            op_we_q      <= winner ? r1_we         : r0_we;
            op_rd_q      <= winner ? r1_rd         : r0_rd;
            load_addr_q  <= winner ? r1_load_addr  : r0_load_addr;
            store_addr_q <= winner ? r1_store_addr : r0_store_addr;
            wdata_q      <= winner ? r1_wdata      : r0_wdata;
            be_q         <= winner ? r1_be         : r0_be;
        end
    end

    // Capture read data for the owner on m_ack; accesses without a read return zero.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else if (state_q == ST_WAIT && m_ack) begin
            if (owner_q) r1_rdata_q <= op_rd_q ? m_read_data : '0;
            else         r0_rdata_q <= op_rd_q ? m_read_data : '0;
        end
    end

    assign r0_rdata      = r0_rdata_q;
    assign r1_rdata      = r1_rdata_q;
    assign m_load_addr   = load_addr_q;
    assign m_store_addr  = store_addr_q;
    assign m_data_store  = wdata_q;
    assign m_byte_enable = be_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter with a
// behavioural memory slave, a reference memory model and per-port expected queues.
// Honours ARB_ROUND_ROBIN_EN for the expected contention grant order.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 15;

    typedef struct packed {
        logic          we;
        logic          rd;
        logic [AW-1:0] la;
        logic [AW-1:0] sa;
        logic [DW-1:0] wd;
        logic [3:0]    be;
    } cmd_t;

    logic          a_clk, a_rst;
    logic          r0_req, r0_we, r0_rd, r1_req, r1_we, r1_rd;
    logic [AW-1:0] r0_load_addr, r0_store_addr, r1_load_addr, r1_store_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;
    logic [3:0]    r0_be, r1_be;
    logic          r0_gnt, r0_ack, r0_err, r1_gnt, r1_ack, r1_err;
    logic          m_cyc, m_stb, m_we, m_rd, m_ack, m_stall;
    logic [AW-1:0] m_load_addr, m_store_addr;
    logic [DW-1:0] m_data_store, m_read_data;
    logic [3:0]    m_byte_enable;
    logic [2:0]    dbg_state;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
        .a_clk(a_clk), .a_rst(a_rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_rd(r0_rd),
        .r0_load_addr(r0_load_addr), .r0_store_addr(r0_store_addr),
        .r0_wdata(r0_wdata), .r0_be(r0_be),
        .r0_gnt(r0_gnt), .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_rd(r1_rd),
        .r1_load_addr(r1_load_addr), .r1_store_addr(r1_store_addr),
        .r1_wdata(r1_wdata), .r1_be(r1_be),
        .r1_gnt(r1_gnt), .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_rd(m_rd),
        .m_load_addr(m_load_addr), .m_store_addr(m_store_addr),
        .m_data_store(m_data_store), .m_byte_enable(m_byte_enable),
        .m_read_data(m_read_data), .m_ack(m_ack), .m_stall(m_stall),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    // ---------------- bench state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem [32];
    logic [DW-1:0] ref_mem [32];
    logic [DW:0]   exp_q0 [$];
    logic [DW:0]   exp_q1 [$];
    int            gnt_log [$];
    cmd_t          cmd0, cmd1, exp_cmd;
    bit            no_ack = 1'b0;
    bit            rand_stall = 1'b0;
    bit            rand_lat = 1'b0;
    int            lat = 1;
    int            stall_left = 0;
    int            cyc_no = 0;
    int            last_stb_cyc = 0;
    int            err_cyc = 0;
    int            stb_run = 0;
    int            last_stb_run = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Reference: result of a command is decided from the spec rules alone.
    function automatic logic [DW:0] model(input cmd_t c);
        logic [DW-1:0] r;
        if (no_ack) return {1'b1, {DW{1'b0}}};
        r = c.rd ? ref_mem[c.la] : '0;
        if (c.we) ref_mem[c.sa] = merge(ref_mem[c.sa], c.wd, c.be);
        return {1'b0, r};
    endfunction

    function automatic cmd_t mk(input logic we, input logic rd, input int la, input int sa,
                                input logic [DW-1:0] wd, input logic [3:0] be);
        cmd_t c;
        c.we = we; c.rd = rd; c.la = AW'(la); c.sa = AW'(sa); c.wd = wd; c.be = be;
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input int p);
        return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  p * 16 + $urandom_range(0, 15), p * 16 + $urandom_range(0, 15),
                  $urandom, 4'($urandom_range(0, 15)));
    endfunction

    // ---------------- driver tasks (called at posedge+2, return at posedge+2) ----------------
    task automatic drive(input int p, input cmd_t c, input logic rq);
        if (p == 0) begin
            cmd0 = c; r0_we = c.we; r0_rd = c.rd; r0_load_addr = c.la;
            r0_store_addr = c.sa; r0_wdata = c.wd; r0_be = c.be; r0_req = rq;
        end else begin
            cmd1 = c; r1_we = c.we; r1_rd = c.rd; r1_load_addr = c.la;
            r1_store_addr = c.sa; r1_wdata = c.wd; r1_be = c.be; r1_req = rq;
        end
    endtask

    task automatic do_req(input int p, input cmd_t c);
        logic [DW:0] e;
        bit          done;
        int          n;
        e = model(c);
        if (p == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        drive(p, c, 1'b1);
        done = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge a_clk);
            n++;
            done = (p == 0) ? (r0_ack | r0_err) : (r1_ack | r1_err);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_resp_p%0d act=none exp=ack_or_err", p);
            if (p == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
        end
        @(posedge a_clk); #2;
        drive(p, c, 1'b0);
    endtask

    // ---------------- memory slave ----------------
    initial begin
        bit pend, acc_prev;
        int wcnt;
        m_ack = 1'b0; m_stall = 1'b0; m_read_data = '0;
        pend = 1'b0; acc_prev = 1'b0; wcnt = 0;
        forever begin
            @(posedge a_clk); #1;
            m_ack = 1'b0;
            if (a_rst) begin
                pend = 1'b0; acc_prev = 1'b0; m_stall = 1'b0;
                continue;
            end
            if (pend) begin
                if (wcnt == 0) begin
                    if (!no_ack) begin
                        m_ack = 1'b1;
                        m_read_data = m_rd ? mem[m_load_addr] : $urandom;
                        if (m_we) mem[m_store_addr] = merge(mem[m_store_addr], m_data_store, m_byte_enable);
                        pend = 1'b0;
                    end
                end else begin
                    wcnt--;
                end
            end
            if (acc_prev) begin
                pend = 1'b1;
                wcnt = (rand_lat ? $urandom_range(1, 3) : lat) - 1;
            end
            if (m_cyc && m_stb) begin
                if (stall_left > 0) begin
                    m_stall = 1'b1;
                    stall_left--;
                end else if (rand_stall && $urandom_range(0, 2) == 0) m_stall = 1'b1;
                else m_stall = 1'b0;
            end else begin
                m_stall = 1'b0;
            end
            acc_prev = m_cyc && m_stb && !m_stall;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge a_clk);
            cyc_no++;
            if (r0_gnt && r1_gnt) chk("dual_gnt", 64'({r0_gnt, r1_gnt}), 64'(2'b10));
            if (r0_gnt) begin exp_cmd = cmd0; gnt_log.push_back(0); end
            else if (r1_gnt) begin exp_cmd = cmd1; gnt_log.push_back(1); end
            if (m_stb) begin
                stb_run++;
                last_stb_cyc = cyc_no;
            end else if (stb_run > 0) begin
                last_stb_run = stb_run;
                stb_run = 0;
            end
            if (m_cyc)
                chk("bus_cmd", 64'({m_we, m_rd, m_load_addr, m_store_addr, m_data_store, m_byte_enable}),
                    64'(exp_cmd));
            else
                chk("bus_idle", 64'({m_stb, m_we, m_rd}), 64'(0));
            if (r0_ack || r0_err) begin
                if (r0_err) err_cyc = cyc_no;
                if (exp_q0.size() == 0) chk("r0_unexpected", 64'({r0_ack, r0_err}), 64'(0));
                else begin
                    e = exp_q0.pop_front();
                    chk("r0_resp", 64'({r0_ack, r0_err, (r0_err ? 32'h0 : r0_rdata)}),
                        64'({~e[DW], e[DW], e[DW-1:0]}));
                end
            end
            if (r1_ack || r1_err) begin
                if (r1_err) err_cyc = cyc_no;
                if (exp_q1.size() == 0) chk("r1_unexpected", 64'({r1_ack, r1_err}), 64'(0));
                else begin
                    e = exp_q1.pop_front();
                    chk("r1_resp", 64'({r1_ack, r1_err, (r1_err ? 32'h0 : r1_rdata)}),
                        64'({~e[DW], e[DW], e[DW-1:0]}));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        cmd_t c;
        int   n;
        int   pulses;
        int   exp_ord [4];

        a_rst = 1'b1;
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);
        exp_cmd = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end

        // Reset values.
        repeat (2) @(posedge a_clk);
        @(negedge a_clk);
        chk("rst_state", 64'(dbg_state), 64'(0));
        chk("rst_bus", 64'({m_cyc, m_stb, m_we, m_rd}), 64'(0));
        chk("rst_pulses", 64'({r0_gnt, r0_ack, r0_err, r1_gnt, r1_ack, r1_err}), 64'(0));
        chk("rst_rdata", 64'({r0_rdata, r1_rdata}), 64'(0));
        chk("rst_fields", 64'({m_load_addr, m_store_addr, m_data_store, m_byte_enable}), 64'(0));
        @(posedge a_clk); #2;
        a_rst = 1'b0;

        // Directed read on r0 with cycle timing.
        mem[3] = 32'hDEADBEEF;
        ref_mem[3] = 32'hDEADBEEF;
        c = mk(1'b0, 1'b1, 3, 0, '0, 4'h0);
        exp_q0.push_back(model(c));
        drive(0, c, 1'b1);
        @(negedge a_clk); chk("rd_c0_gnt", 64'({r0_gnt, r1_gnt, m_stb}), 64'(3'b100));
        @(negedge a_clk); chk("rd_c1_stb", 64'({r0_gnt, m_cyc, m_stb}), 64'(3'b011));
        @(negedge a_clk); chk("rd_c2_wait", 64'({m_cyc, m_stb, m_rd}), 64'(3'b101));
        @(negedge a_clk); chk("rd_c3_noack", 64'(r0_ack), 64'(0));
        @(negedge a_clk);
        chk("rd_c4_ack", 64'({r0_ack, r1_ack, r1_err, r1_gnt}), 64'(4'b1000));
        chk("rd_c4_rdata", 64'(r0_rdata), 64'(32'hDEADBEEF));
        chk("rd_r1_rdata", 64'(r1_rdata), 64'(0));
        @(posedge a_clk); #2;
        drive(0, c, 1'b0);

        // Byte-enable write on r1, then read back.
        mem[5] = 32'h11223344;
        ref_mem[5] = 32'h11223344;
        do_req(1, mk(1'b1, 1'b0, 0, 5, 32'hAABBCCDD, 4'b0101));
        do_req(1, mk(1'b0, 1'b1, 5, 0, '0, 4'h0));
        chk("byte_merge", 64'(r1_rdata), 64'(32'h11BB33DD));

        // Read+write together, and a command with neither.
        do_req(0, mk(1'b1, 1'b1, 8, 8, 32'h0BADF00D, 4'b1111));
        do_req(0, mk(1'b0, 1'b1, 8, 0, '0, 4'h0));
        do_req(0, mk(1'b0, 1'b0, 9, 10, 32'h12345678, 4'b1111));
        chk("nop_rdata", 64'(r0_rdata), 64'(0));

        // Stall during ISSUE: strobe held 4 cycles.
        stall_left = 3;
        do_req(0, mk(1'b1, 1'b1, 7, 6, 32'hCAFE0001, 4'b1100));
        chk("stall_len", 64'(last_stb_run), 64'(4));

        // Timeout: memory never acks.
        no_ack = 1'b1;
        do_req(0, mk(1'b0, 1'b1, 2, 0, '0, 4'h0));
        chk("to_latency", 64'(err_cyc - last_stb_cyc), 64'(16));
        chk("to_bus_drop", 64'({m_cyc, r0_ack, r0_err}), 64'(0));
        no_ack = 1'b0;
        repeat (4) @(posedge a_clk);
        #2;

        // Reset while in WAIT kills the transaction silently.
        lat = 10;
        c = mk(1'b0, 1'b1, 4, 0, '0, 4'h0);
        drive(0, c, 1'b1);
        n = 0;
        while (!(m_cyc && !m_stb) && n < 20) begin
            @(negedge a_clk);
            n++;
        end
        chk("rw_reach_wait", 64'(m_cyc && !m_stb), 64'(1));
        @(posedge a_clk); #2;
        a_rst = 1'b1;
        drive(0, c, 1'b0);
        @(posedge a_clk); #2;
        a_rst = 1'b0;
        @(negedge a_clk);
        chk("rw_idle", 64'({dbg_state, m_cyc}), 64'(0));
        pulses = 0;
        repeat (15) begin
            @(negedge a_clk);
            if (r0_ack || r0_err || r1_ack || r1_err) pulses++;
        end
        chk("rw_no_pulse", 64'(pulses), 64'(0));
        lat = 1;
        @(posedge a_clk); #2;
        do_req(0, mk(1'b0, 1'b1, 4, 0, '0, 4'h0));

        // Contention: both ports hold requests for two reads each.
        a_rst = 1'b1;
        @(posedge a_clk); #2;
        a_rst = 1'b0;
        gnt_log.delete();
        fork
            begin
                do_req(0, mk(1'b0, 1'b1, 1, 0, '0, 4'h0));
                do_req(0, mk(1'b0, 1'b1, 2, 0, '0, 4'h0));
            end
            begin
                do_req(1, mk(1'b0, 1'b1, 17, 0, '0, 4'h0));
                do_req(1, mk(1'b0, 1'b1, 18, 0, '0, 4'h0));
            end
        join
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 1, 1};
`endif
        chk("arb_count", 64'(gnt_log.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < gnt_log.size()) chk($sformatf("arb_order_%0d", i), 64'(gnt_log[i]), 64'(exp_ord[i]));

        // Randomized concurrent traffic on disjoint address halves.
        rand_stall = 1'b1;
        rand_lat = 1'b1;
        fork
            for (int i = 0; i < 25; i++) do_req(0, rand_cmd(0));
            for (int j = 0; j < 25; j++) do_req(1, rand_cmd(1));
        join
        rand_stall = 1'b0;
        rand_lat = 1'b0;

        repeat (5) @(negedge a_clk);
        chk("q_drain", 64'(exp_q0.size() + exp_q1.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
